// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width
// and the signed-overflow rule used when ADD_OVF_EN is defined.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
  function automatic logic signedOverflow(input logic aMsb, input logic bMsb, input logic sumMsb);
    return (aMsb == bMsb) && (sumMsb != aMsb);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// 4-bit ripple-carry adder slice (add4), reused once per nibble by the
// serial adder.
module add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                co_o
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = ci_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = carry[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder sequencing one add4 slice over WIDTH/4 nibbles,
// LSB first. Define ADD_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  aSh_q, aSh_d;
  logic [WIDTH-1:0]  bSh_q, bSh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              co_q, co_d;
`ifdef ADD_OVF_EN
  logic              aMsb_q, aMsb_d;
  logic              bMsb_q, bMsb_d;
  logic              ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] sliceSum;
  logic                sliceCo;

  add4 u_add4 (
    .a_i   (aSh_q[NIBBLE_W-1:0]),
    .b_i   (bSh_q[NIBBLE_W-1:0]),
    .ci_i  (carry_q),
    .sum_o (sliceSum),
    .co_o  (sliceCo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      co_q    <= 1'b0;
`ifdef ADD_OVF_EN
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
`ifdef ADD_OVF_EN
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    co_d    = co_q;
`ifdef ADD_OVF_EN
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = ci;
          cnt_d   = CW'(NIB - 1);
`ifdef ADD_OVF_EN
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Each slice result enters at the top so that after NIB shifts nibble 0 sits at the bottom.
        aSh_d   = aSh_q >> NIBBLE_W;
        bSh_d   = bSh_q >> NIBBLE_W;
        res_d   = res_q >> NIBBLE_W;
        res_d[WIDTH-1 -: NIBBLE_W] = sliceSum;
        carry_d = sliceCo;
        if (cnt_q == '0) begin
          co_d    = sliceCo;
`ifdef ADD_OVF_EN
          ovf_d   = signedOverflow(aMsb_q, bMsb_q, sliceSum[NIBBLE_W-1]);
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = res_q;
  assign co        = co_q;
`ifdef ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
